// File: rtl/ram_fifo_pkg.sv
// Shared definitions for the RAM-backed FIFO controller: pointer width helper
// and the bit positions of the optional sticky status flags.
package ram_fifo_pkg;

    // Pointers carry one extra wrap bit above the RAM address
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    localparam int STATUS_OVERFLOW_BIT  = 0;
    localparam int STATUS_UNDERFLOW_BIT = 1;
    localparam int STATUS_FLAG_COUNT    = 2;

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Bundle of the push/pop streams and the dual-port RAM signals of ram_fifo_ctrl.
// The slave modport is the controller's view, the master modport the parent's.
// Optional status signals exist only when RAM_FIFO_CTRL_STATUS_EN is defined.
interface ram_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  flush_i;
    logic                  push_valid_i;
    logic                  push_ready_o;
    logic [DATA_WIDTH-1:0] push_data_i;
    logic                  pop_valid_o;
    logic                  pop_ready_i;
    logic [DATA_WIDTH-1:0] pop_data_o;
    logic                  ram_write_en_o;
    logic [ADDR_WIDTH-1:0] ram_write_addr_o;
    logic [DATA_WIDTH-1:0] ram_wdata_o;
    logic                  ram_read_en_o;
    logic [ADDR_WIDTH-1:0] ram_read_addr_o;
    logic [DATA_WIDTH-1:0] ram_rdata_i;
`ifdef RAM_FIFO_CTRL_STATUS_EN
    logic [ADDR_WIDTH:0]   level_o;
    logic                  overflow_o;
    logic                  underflow_o;
`endif

    modport slave (
`ifdef RAM_FIFO_CTRL_STATUS_EN
        output level_o, overflow_o, underflow_o,
`endif
        input  flush_i, push_valid_i, push_data_i, pop_ready_i, ram_rdata_i,
        output push_ready_o, pop_valid_o, pop_data_o,
        output ram_write_en_o, ram_write_addr_o, ram_wdata_o,
        output ram_read_en_o, ram_read_addr_o
    );

    modport master (
`ifdef RAM_FIFO_CTRL_STATUS_EN
        input  level_o, overflow_o, underflow_o,
`endif
        output flush_i, push_valid_i, push_data_i, pop_ready_i, ram_rdata_i,
        input  push_ready_o, pop_valid_o, pop_data_o,
        input  ram_write_en_o, ram_write_addr_o, ram_wdata_o,
        input  ram_read_en_o, ram_read_addr_o
    );

endinterface

// File: rtl/ram_fifo_ptr.sv
// Wrap-bit pointer counter used for both the write and read side of the FIFO.
// Clear has priority over increment; the count wraps modulo 2**WIDTH.
module ram_fifo_ptr #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] ptr
);

    // Pointer register: async reset, synchronous clear, then increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a dual-port RAM with combinational read data.
// Owns the pointers and full/empty; the RAM (instantiated by the parent) holds data.
// Optional feature macro: RAM_FIFO_CTRL_STATUS_EN adds level_o, overflow_o, underflow_o.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input logic              clk,
    input logic              rst_n,
    ram_fifo_ctrl_if.slave   bus
);

    localparam int PW = ptr_width(ADDR_WIDTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    ram_fifo_ptr #(.WIDTH(PW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (push & ~bus.flush_i),
        .clr   (bus.flush_i),
        .ptr   (wr_ptr)
    );

    ram_fifo_ptr #(.WIDTH(PW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pop & ~bus.flush_i),
        .clr   (bus.flush_i),
        .ptr   (rd_ptr)
    );

    // Occupancy flags and handshakes, purely from the registered pointers
    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
        push  = bus.push_valid_i & ~full;
        pop   = bus.pop_ready_i & ~empty;
    end

    // RAM port drive; the write strobe is also held low while reset is asserted
    always_comb begin
        bus.push_ready_o     = ~full;
        bus.pop_valid_o      = ~empty;
        bus.pop_data_o       = bus.ram_rdata_i;
        bus.ram_write_en_o   = push & ~bus.flush_i & rst_n;
        bus.ram_write_addr_o = wr_ptr[ADDR_WIDTH-1:0];
        bus.ram_wdata_o      = bus.push_data_i;
        bus.ram_read_en_o    = ~empty;
        bus.ram_read_addr_o  = rd_ptr[ADDR_WIDTH-1:0];
    end

`ifdef RAM_FIFO_CTRL_STATUS_EN
    logic [STATUS_FLAG_COUNT-1:0] status_q;

    // Sticky misuse flags: a push attempt while full or a pop attempt while empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= '0;
        end else if (bus.flush_i) begin
            status_q <= '0;
        end else begin
            if (bus.push_valid_i && full) begin
                status_q[STATUS_OVERFLOW_BIT] <= 1'b1;
            end
            if (bus.pop_ready_i && empty) begin
                status_q[STATUS_UNDERFLOW_BIT] <= 1'b1;
            end
        end
    end

    // Fill level and flag outputs
    always_comb begin
        bus.level_o     = wr_ptr - rd_ptr;
        bus.overflow_o  = status_q[STATUS_OVERFLOW_BIT];
        bus.underflow_o = status_q[STATUS_UNDERFLOW_BIT];
    end
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed testbench for ram_fifo_ctrl with a depth-4 behavioural dual-port RAM.
// Build with RAM_FIFO_CTRL_STATUS_EN defined to also cover the status outputs.
module tb_ram_fifo_ctrl;

    localparam int DW = 8;
    localparam int AW = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [DW-1:0] mem [4];

    ram_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural RAM: synchronous write, combinational read
    always_ff @(posedge clk) begin
        if (bus.ram_write_en_o) begin
            mem[bus.ram_write_addr_o] <= bus.ram_wdata_o;
        end
    end

    // Combinational read port of the RAM
    always_comb begin
        bus.ram_rdata_i = mem[bus.ram_read_addr_o];
    end

    // Runaway guard so the bench always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, required finish before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic pv, input logic [DW-1:0] pd,
                                 input logic pr, input logic fl);
        bus.push_valid_i = pv;
        bus.push_data_i  = pd;
        bus.pop_ready_i  = pr;
        bus.flush_i      = fl;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Directed sequence covering reset, fill, drain, streaming, flush and async reset
    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        #2;
        checkOutput("rst_push_ready", 32'(bus.push_ready_o), 32'd1);
        checkOutput("rst_pop_valid", 32'(bus.pop_valid_o), 32'd0);
        checkOutput("rst_write_en", 32'(bus.ram_write_en_o), 32'd0);
        rst_n = 1'b1;

        // 1: idle after reset
        nextCycle();
        checkOutput("idle_push_ready", 32'(bus.push_ready_o), 32'd1);
        checkOutput("idle_pop_valid", 32'(bus.pop_valid_o), 32'd0);
        checkOutput("idle_read_en", 32'(bus.ram_read_en_o), 32'd0);
        checkOutput("idle_waddr", 32'(bus.ram_write_addr_o), 32'd0);
        checkOutput("idle_raddr", 32'(bus.ram_read_addr_o), 32'd0);

        // 2: fill with A1..A4, then a held fifth push
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0);
            #1;
            checkOutput("fill_push_ready", 32'(bus.push_ready_o), 32'd1);
            checkOutput("fill_write_en", 32'(bus.ram_write_en_o), 32'd1);
            checkOutput("fill_waddr", 32'(bus.ram_write_addr_o), 32'(i));
            nextCycle();
        end
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        #1;
        checkOutput("full_push_ready", 32'(bus.push_ready_o), 32'd0);
        checkOutput("full_write_en", 32'(bus.ram_write_en_o), 32'd0);
        checkOutput("full_pop_valid", 32'(bus.pop_valid_o), 32'd1);
`ifdef RAM_FIFO_CTRL_STATUS_EN
        checkOutput("full_level", 32'(bus.level_o), 32'd4);
`endif
        nextCycle();
        checkOutput("full_hold_ready", 32'(bus.push_ready_o), 32'd0);
        checkOutput("full_hold_waddr", 32'(bus.ram_write_addr_o), 32'd0);
`ifdef RAM_FIFO_CTRL_STATUS_EN
        checkOutput("full_overflow", 32'(bus.overflow_o), 32'd1);
`endif

        // 3: drain in order
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            #1;
            checkOutput("drain_pop_valid", 32'(bus.pop_valid_o), 32'd1);
            checkOutput("drain_data", 32'(bus.pop_data_o), 32'(8'hA1 + 8'(i)));
            checkOutput("drain_raddr", 32'(bus.ram_read_addr_o), 32'(i));
            nextCycle();
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        checkOutput("drained_pop_valid", 32'(bus.pop_valid_o), 32'd0);
        checkOutput("drained_push_ready", 32'(bus.push_ready_o), 32'd1);

        // 4: one entry primed, then 20 cycles of simultaneous push and pop
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b0);
        nextCycle();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 8'h11 + 8'(i), 1'b1, 1'b0);
            #1;
            checkOutput("stream_pop_valid", 32'(bus.pop_valid_o), 32'd1);
            checkOutput("stream_push_ready", 32'(bus.push_ready_o), 32'd1);
            checkOutput("stream_data", 32'(bus.pop_data_o), 32'(8'h10 + 8'(i)));
`ifdef RAM_FIFO_CTRL_STATUS_EN
            checkOutput("stream_level", 32'(bus.level_o), 32'd1);
`endif
            nextCycle();
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        #1;
        checkOutput("stream_last_data", 32'(bus.pop_data_o), 32'h24);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        checkOutput("stream_empty", 32'(bus.pop_valid_o), 32'd0);

        // 5: three entries then flush together with a push
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'hC1 + 8'(i), 1'b0, 1'b0);
            nextCycle();
        end
        applyStimulus(1'b1, 8'hCC, 1'b0, 1'b1);
        #1;
        checkOutput("flush_write_en", 32'(bus.ram_write_en_o), 32'd0);
        checkOutput("flush_pop_valid_before", 32'(bus.pop_valid_o), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        checkOutput("flush_pop_valid", 32'(bus.pop_valid_o), 32'd0);
        checkOutput("flush_push_ready", 32'(bus.push_ready_o), 32'd1);
        checkOutput("flush_waddr", 32'(bus.ram_write_addr_o), 32'd0);
        checkOutput("flush_raddr", 32'(bus.ram_read_addr_o), 32'd0);
`ifdef RAM_FIFO_CTRL_STATUS_EN
        checkOutput("flush_overflow", 32'(bus.overflow_o), 32'd0);
        checkOutput("flush_level", 32'(bus.level_o), 32'd0);
`endif

        // 6: fill to full with push held, then async reset mid-cycle
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'hD1 + 8'(i), 1'b0, 1'b0);
            nextCycle();
        end
        applyStimulus(1'b1, 8'hD5, 1'b0, 1'b0);
        nextCycle();
        checkOutput("pre_rst_push_ready", 32'(bus.push_ready_o), 32'd0);
`ifdef RAM_FIFO_CTRL_STATUS_EN
        checkOutput("pre_rst_overflow", 32'(bus.overflow_o), 32'd1);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_push_ready", 32'(bus.push_ready_o), 32'd1);
        checkOutput("arst_pop_valid", 32'(bus.pop_valid_o), 32'd0);
        checkOutput("arst_write_en", 32'(bus.ram_write_en_o), 32'd0);
        checkOutput("arst_read_en", 32'(bus.ram_read_en_o), 32'd0);
        checkOutput("arst_waddr", 32'(bus.ram_write_addr_o), 32'd0);
        checkOutput("arst_raddr", 32'(bus.ram_read_addr_o), 32'd0);
`ifdef RAM_FIFO_CTRL_STATUS_EN
        checkOutput("arst_overflow", 32'(bus.overflow_o), 32'd0);
        checkOutput("arst_level", 32'(bus.level_o), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        nextCycle();
        checkOutput("post_rst_pop_valid", 32'(bus.pop_valid_o), 32'd0);
        checkOutput("post_rst_push_ready", 32'(bus.push_ready_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
